// File: rtl/pwm_sample_feeder.sv
// pwm_sample_feeder
//
// Buffers signed anti-noise samples from the filter stage and hands one
// offset-binary duty word to the PWM stage per 2048-cycle PWM period.
//
// Each accepted sample is arithmetically shifted right by SHIFT, saturated
// to -512..+511 and re-biased by +512 into a 10-bit word (0x200 = silence).
// Words wait in a DEPTH-entry FIFO. On the edge that ends the last cycle of
// a period the oldest word moves to SigVec. If the FIFO is empty on that
// edge, SigVec falls back to mid-scale and Underrun is raised.
//
// Ports
//   Clk_pwm     in   1  sole clock, shared with the PWM stage
//   Rst         in   1  synchronous active-high reset
//   SampleIn    in  16  signed sample
//   SampleValid in   1  SampleIn valid this cycle
//   SampleReady out  1  feeder accepts a sample this cycle
//   FlagClr     in   1  clears Underrun and Clip on the next edge
//   SigVec      out 10  offset-binary duty word, changes only at period end
//   PeriodEnd   out  1  high during the last cycle of each period
//   FifoLevel   out  5  samples held, 0..DEPTH
//   Underrun    out  1  sticky: a period boundary found the FIFO empty
//   Clip        out  1  sticky: an accepted sample saturated
//
// Handshake: a sample is transferred on every rising edge where SampleValid
// and SampleReady are both high. SampleReady does not depend on SampleValid;
// SampleValid may be raised or dropped freely, and SampleIn matters only on
// transfer edges.

module pwm_sample_feeder #(
  parameter int DEPTH = 8,
  parameter int SHIFT = 6
) (
  input  logic        Clk_pwm,
  input  logic        Rst,
  input  logic [15:0] SampleIn,
  input  logic        SampleValid,
  output logic        SampleReady,
  input  logic        FlagClr,
  output logic [9:0]  SigVec,
  output logic        PeriodEnd,
  output logic [4:0]  FifoLevel,
  output logic        Underrun,
  output logic        Clip
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);
  localparam logic [9:0] MID     = 10'h200;

  logic [10:0]   cnt_q, cnt_d;
  logic          period_end_q, period_end_d;
  logic [4:0]    level_q, level_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [9:0]    sig_vec_q, sig_vec_d;
  logic          underrun_q, underrun_d;
  logic          clip_q, clip_d;
  logic [9:0]    mem_q [DEPTH];

  logic               ready;
  logic               push;
  logic               pop_slot;
  logic               pop;
  logic signed [15:0] shifted;
  logic [9:0]         sat;
  logic               sat_hit;
  logic [9:0]         conv;

  always_comb begin
    ready    = !Rst && (level_q < DEPTH_L);
    push     = SampleValid && ready;
    // period_end_q marks the last cycle of the period, so the edge that
    // ends it is the pop slot. The level is sampled before this edge's push,
    // so a sample arriving on the slot edge itself waits a full period.
    pop_slot = period_end_q && !Rst;
    pop      = pop_slot && (level_q != 5'd0);

    shifted = $signed(SampleIn) >>> SHIFT;
    sat_hit = 1'b0;
    sat     = shifted[9:0];
    if (shifted > 16'sd511) begin
      sat     = 10'h1FF;
      sat_hit = 1'b1;
    end else if (shifted < -16'sd512) begin
      sat     = 10'h200;
      sat_hit = 1'b1;
    end
    // Adding 512 to a 10-bit two's-complement value just flips its MSB.
    conv = {~sat[9], sat[8:0]};

    cnt_d        = cnt_q + 11'd1;
    // Registered so PeriodEnd is high exactly while cnt_q == 2047.
    period_end_d = (cnt_q == 11'd2046);

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    sig_vec_d = sig_vec_q;
    if (pop_slot) begin
      sig_vec_d = pop ? mem_q[rd_ptr_q] : MID;
    end

    // Clear first, then set, so a coinciding set condition wins.
    underrun_d = FlagClr ? 1'b0 : underrun_q;
    if (pop_slot && (level_q == 5'd0)) begin
      underrun_d = 1'b1;
    end
    clip_d = FlagClr ? 1'b0 : clip_q;
    if (push && sat_hit) begin
      clip_d = 1'b1;
    end
  end

  always_ff @(posedge Clk_pwm) begin
    if (Rst) begin
      cnt_q        <= 11'd0;
      period_end_q <= 1'b0;
      level_q      <= 5'd0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      sig_vec_q    <= MID;
      underrun_q   <= 1'b0;
      clip_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      period_end_q <= period_end_d;
      level_q      <= level_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      sig_vec_q    <= sig_vec_d;
      underrun_q   <= underrun_d;
      clip_q       <= clip_d;
    end
  end

  // Storage needs no reset: entries are only read below the fill level.
  always_ff @(posedge Clk_pwm) begin
    if (push) begin
      mem_q[wr_ptr_q] <= conv;
    end
  end

  assign SampleReady = ready;
  assign SigVec      = sig_vec_q;
  assign PeriodEnd   = period_end_q;
  assign FifoLevel   = level_q;
  assign Underrun    = underrun_q;
  assign Clip        = clip_q;

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Directed bench for pwm_sample_feeder. u_dut uses SHIFT=6, u_dut4 uses
// SHIFT=4 for the saturation case; both share clock, reset and FlagClr.
module tb_pwm_sample_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flag_clr = 1'b0;
  logic        valid6 = 1'b0;
  logic        valid4 = 1'b0;
  logic [15:0] sample_in = 16'h0000;

  logic        ready6, pe6, und6, clip6;
  logic [9:0]  sig6;
  logic [4:0]  lvl6;
  logic        ready4, pe4, und4, clip4;
  logic [9:0]  sig4;
  logic [4:0]  lvl4;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  pwm_sample_feeder #(.DEPTH(8), .SHIFT(6)) u_dut (
    .Clk_pwm(clk), .Rst(rst), .SampleIn(sample_in), .SampleValid(valid6),
    .SampleReady(ready6), .FlagClr(flag_clr), .SigVec(sig6),
    .PeriodEnd(pe6), .FifoLevel(lvl6), .Underrun(und6), .Clip(clip6)
  );

  pwm_sample_feeder #(.DEPTH(8), .SHIFT(4)) u_dut4 (
    .Clk_pwm(clk), .Rst(rst), .SampleIn(sample_in), .SampleValid(valid4),
    .SampleReady(ready4), .FlagClr(flag_clr), .SigVec(sig4),
    .PeriodEnd(pe4), .FifoLevel(lvl4), .Underrun(und4), .Clip(clip4)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until PeriodEnd is high (last cycle of the period); n = edges taken.
  task automatic wait_pe(output int n);
    n = 0;
    while (pe6 !== 1'b1 && n < 4100) begin
      step();
      n++;
    end
    if (n >= 4100) check("pe_timeout", {15'b0, pe6}, 16'd1);
  endtask

  task automatic push6(input logic [15:0] v);
    sample_in = v;
    valid6    = 1'b1;
    step();
    valid6    = 1'b0;
  endtask

  // Step through the boundary edge that ends the current period.
  task automatic next_boundary();
    int n;
    wait_pe(n);
    step();
  endtask

  logic [15:0] conv_in  [4];
  logic [15:0] conv_exp [4];

  initial begin
    int n;
    conv_in[0]  = 16'h0000; conv_exp[0] = 16'h200;
    conv_in[1]  = 16'h7FFF; conv_exp[1] = 16'h3FF;
    conv_in[2]  = 16'h8000; conv_exp[2] = 16'h000;
    conv_in[3]  = 16'h0040; conv_exp[3] = 16'h201;

    // ---- reset: two edges with Rst high
    step();
    step();
    check("rst_ready_low", {15'b0, ready6}, 16'd0);
    check("rst_pe_low",    {15'b0, pe6},    16'd0);
    check("rst_level",     {11'b0, lvl6},   16'd0);
    check("rst_sigvec",    {6'b0, sig6},    16'h200);
    rst = 1'b0;
    #1;
    check("rel_ready",     {15'b0, ready6}, 16'd1);
    check("rel_underrun",  {15'b0, und6},   16'd0);
    check("rel_clip",      {15'b0, clip6},  16'd0);
    wait_pe(n);
    check("first_period", 16'(n), 16'd2047);
    step();
    check("empty_sigvec",  {6'b0, sig6},    16'h200);
    check("empty_underrun",{15'b0, und6},   16'd1);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    check("underrun_clr",  {15'b0, und6},   16'd0);

    // ---- conversion with SHIFT=6
    for (int i = 0; i < 4; i++) push6(conv_in[i]);
    check("conv_level", {11'b0, lvl6}, 16'd4);
    for (int i = 0; i < 4; i++) begin
      next_boundary();
      check($sformatf("conv_sig%0d", i), {6'b0, sig6}, conv_exp[i]);
      if (i == 0) begin
        repeat (1000) step();
        check("sig_stable", {6'b0, sig6}, conv_exp[0]);
      end
    end
    check("conv_clip", {15'b0, clip6}, 16'd0);

    // ---- saturation with SHIFT=4 on u_dut4
    sample_in = 16'h4000;
    valid4    = 1'b1;
    step();
    valid4    = 1'b0;
    check("sat_clip",  {15'b0, clip4}, 16'd1);
    check("sat_level", {11'b0, lvl4},  16'd1);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    check("sat_clip_clr", {15'b0, clip4}, 16'd0);
    next_boundary();
    check("sat_sigvec", {6'b0, sig4}, 16'h3FF);

    // ---- full: 9 back-to-back pushes into DEPTH=8
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    check("full_und_pre", {15'b0, und6}, 16'd0);
    for (int i = 0; i < 9; i++) begin
      sample_in = 16'((i + 1) * 64);
      valid6    = 1'b1;
      #1;
      check($sformatf("full_ready%0d", i), {15'b0, ready6}, (i < 8) ? 16'd1 : 16'd0);
      step();
    end
    valid6 = 1'b0;
    check("full_level", {11'b0, lvl6},   16'd8);
    check("full_ready", {15'b0, ready6}, 16'd0);
    next_boundary();
    check("full_pop0",  {6'b0, sig6},    16'h201);
    check("full_ready_back", {15'b0, ready6}, 16'd1);
    check("full_level7", {11'b0, lvl6},  16'd7);
    for (int k = 1; k < 8; k++) begin
      next_boundary();
      check($sformatf("drain%0d", k), {6'b0, sig6}, 16'(16'h201 + k));
    end
    check("drain_level", {11'b0, lvl6}, 16'd0);
    // empty boundary with FlagClr coinciding: set wins
    wait_pe(n);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    check("drain_sigvec",  {6'b0, sig6},  16'h200);
    check("set_priority",  {15'b0, und6}, 16'd1);
    step();
    check("und_clear", {15'b0, und6}, 16'd1);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    check("und_cleared", {15'b0, und6}, 16'd0);

    // ---- simultaneous push/pop at level 3 and level 1
    push6(16'h0400);
    push6(16'h0440);
    push6(16'h0480);
    wait_pe(n);
    sample_in = 16'h04C0;
    valid6    = 1'b1;
    step();
    valid6    = 1'b0;
    check("pp3_level", {11'b0, lvl6}, 16'd3);
    check("pp3_sig",   {6'b0, sig6},  16'h210);
    next_boundary();
    check("pp_sig_b",  {6'b0, sig6},  16'h211);
    next_boundary();
    check("pp_sig_c",  {6'b0, sig6},  16'h212);
    check("pp_level1", {11'b0, lvl6}, 16'd1);
    wait_pe(n);
    sample_in = 16'h0500;
    valid6    = 1'b1;
    step();
    valid6    = 1'b0;
    check("pp1_level", {11'b0, lvl6}, 16'd1);
    check("pp1_sig",   {6'b0, sig6},  16'h213);
    next_boundary();
    check("pp1_next",  {6'b0, sig6},  16'h214);

    // ---- minimum latency: push on the boundary edge into empty FIFO
    wait_pe(n);
    sample_in = 16'h0540;
    valid6    = 1'b1;
    step();
    valid6    = 1'b0;
    check("lat_sig_mid", {6'b0, sig6},  16'h200);
    check("lat_level",   {11'b0, lvl6}, 16'd1);
    next_boundary();
    check("lat_sig",     {6'b0, sig6},  16'h215);

    // ---- reset mid-operation at counter 1000 with level 5
    for (int i = 0; i < 5; i++) push6(16'h1000);
    repeat (995) step();
    check("mid_level5", {11'b0, lvl6}, 16'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {15'b0, ready6}, 16'd0);
    step();
    rst = 1'b0;
    check("mid_level",  {11'b0, lvl6},  16'd0);
    check("mid_sigvec", {6'b0, sig6},   16'h200);
    check("mid_und",    {15'b0, und6},  16'd0);
    wait_pe(n);
    check("mid_period", 16'(n), 16'd2047);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pwm_sample_feeder.md
PWM_SAMPLE_FEEDER -- requirements
Module: pwm_sample_feeder

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in samples (power of two, 2..16).
REQ-002 Parameter SHIFT, default 6, arithmetic right-shift applied to each input sample before saturation (0..15).
REQ-003 Clk_pwm  input  1  sole clock, same clock that drives the downstream PWM stage; all logic on rising edge.
REQ-004 Rst  input  1  reset, synchronous and active-high.
REQ-005 SampleIn  input  16  signed two's-complement anti-noise sample from the filter stage.
REQ-006 SampleValid  input  1  SampleIn is valid this cycle.
REQ-007 SampleReady  output  1  feeder accepts a sample this cycle.
REQ-008 FlagClr  input  1  clears the sticky status flags.
REQ-009 SigVec  output  10  offset-binary duty word for the PWM stage; 0x200 is mid-scale (silence).
REQ-010 PeriodEnd  output  1  high during the last cycle of each 2048-cycle PWM period.
REQ-011 FifoLevel  output  5  number of samples currently held, 0..DEPTH.
REQ-012 Underrun  output  1  sticky: a period boundary found the FIFO empty.
REQ-013 Clip  output  1  sticky: at least one accepted sample saturated.

Function
REQ-014 The block shall contain an 11-bit period counter that increments by 1 every cycle and wraps from 2047 to 0.
REQ-015 PeriodEnd shall be high exactly when the period counter equals 2047, i.e. one cycle in every 2048.
REQ-016 A sample shall be accepted ("push") in any cycle where SampleValid and SampleReady are both high.
REQ-017 SampleReady shall be high when not in reset and FifoLevel < DEPTH, and low otherwise.
REQ-018 Conversion on push: arithmetic right shift of SampleIn by SHIFT, saturation to the range -512..+511, then addition of 512, giving a 10-bit value 0..1023 that is written to the FIFO.
REQ-019 If saturation changed the value in REQ-018, Clip shall be set on the same edge as the push.
REQ-020 Pop: on the rising edge that ends a PeriodEnd cycle, if FifoLevel > 0, the oldest FIFO entry shall be loaded into SigVec and removed from the FIFO.
REQ-021 If FifoLevel = 0 on that edge, SigVec shall be loaded with 0x200 and Underrun shall be set.
REQ-022 SigVec shall change only on the edge defined in REQ-020; it shall be stable throughout every counter value 0..2047.
REQ-023 On a simultaneous push and pop, FifoLevel shall be unchanged and data order shall be preserved, including at level 1.
REQ-024 FifoLevel shall be updated on the same edge as a push or pop.
REQ-025 FifoLevel shall never exceed DEPTH, and the FIFO shall be strictly first-in, first-out.
REQ-026 Minimum latency: a sample pushed into an empty FIFO on the edge ending a PeriodEnd cycle shall not be popped on that edge; it shall appear on SigVec one full period later.
REQ-027 FlagClr high shall clear Underrun and Clip on the next edge.
REQ-028 If a set condition and FlagClr coincide on the same edge, the flag shall be set, because set has priority.

Reset
REQ-029 While Rst is high on an edge:
  - the period counter shall go to 0;
  - the FIFO shall be emptied (FifoLevel = 0);
  - SigVec shall be loaded with 0x200;
  - Underrun and Clip shall be cleared;
  - PeriodEnd shall be low.
REQ-030 SampleReady shall be low while Rst is high.
REQ-031 No push or pop shall occur in a cycle where Rst is high.
REQ-032 Reset asserted mid-period shall discard all buffered samples, and counting shall restart from 0 on the first cycle after Rst falls.

Verification
REQ-033 Reset: hold Rst for 2 cycles, then release -> SigVec = 0x200, FifoLevel = 0, SampleReady = 1, flags = 0, PeriodEnd first high 2047 cycles after release.
REQ-034 Conversion (SHIFT = 6): push 0x0000, 0x7FFF, 0x8000, 0x0040 -> SigVec = 0x200, 0x3FF, 0x000, 0x201 on four successive period boundaries, and Clip = 0.
REQ-035 Saturation (SHIFT = 4): push 0x4000 -> stored value 0x3FF and Clip = 1; then assert FlagClr -> Clip = 0 on the next cycle.
REQ-036 Full: push 9 samples back-to-back within one period (DEPTH = 8) -> SampleReady falls after the 8th push, the 9th sample is not accepted, FifoLevel = 8, and SampleReady rises after the next pop.
REQ-037 Underrun plus simultaneous push/pop:
  - Let the FIFO drain empty -> at the next boundary SigVec = 0x200 and Underrun = 1.
  - Refill to level 3 and push during the PeriodEnd cycle -> FifoLevel stays 3.
REQ-038 Reset mid-operation: with FifoLevel = 5 at counter 1000, pulse Rst -> FifoLevel = 0, SigVec = 0x200, and the next PeriodEnd occurs 2047 cycles after Rst falls.
